// File: rtl/wall_height_buffer.sv
// wall_height_buffer: queues ray-tracer column results, converts UQ7.9
// perpendicular distance into a clamped wall height with an 8-step restoring
// divider, and stores {height, side, tex} per column for the VGA renderer.
module wall_height_buffer #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_HEIGHT = 240,
    parameter int HEIGHT_NUM = 131072,
    parameter int COL_BASE   = 64,
    parameter int COLS       = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        store,
    input  logic [9:0]  column,
    input  logic        side,
    input  logic [15:0] vdist,
    input  logic [5:0]  tex,
    input  logic [9:0]  rd_col,
    output logic [7:0]  rd_height,
    output logic        rd_side,
    output logic [5:0]  rd_tex,
    output logic        busy,
    output logic        overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(COLS);
    localparam int ENT_W = IDX_W + 1 + 16 + 6;
    localparam int RAM_W = 8 + 1 + 6;

    typedef enum logic [1:0] {IDLE, DIV, WRITE} state_t;
    state_t state, state_next;

    // Capture side: column range check and FIFO bookkeeping
    logic [31:0]      col_off;
    logic             col_ok;
    logic             push, pop, full, empty, we;
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [ENT_W-1:0] head;
    logic [IDX_W-1:0] head_idx;
    logic             head_side;
    logic [15:0]      head_vdist;
    logic [5:0]       head_tex;
    logic [31:0]      head_prod;
    logic             clamp;

    // Working registers for the entry being serviced
    logic [IDX_W-1:0] w_idx;
    logic             w_side;
    logic [15:0]      w_vdist;
    logic [5:0]       w_tex;
    logic [31:0]      rem, div_sh, rem_next;
    logic [7:0]       q, q_next, height;
    logic [2:0]       bit_cnt;
    logic             take;

    // Column buffer and read side
    logic [RAM_W-1:0] ram [COLS];
    logic [31:0]      rd_off;
    logic             rd_ok;

    assign col_off = 32'(column) - 32'(COL_BASE);
    assign col_ok  = (32'(column) >= 32'(COL_BASE)) && (col_off < 32'(COLS));
    assign rd_off  = 32'(rd_col) - 32'(COL_BASE);
    assign rd_ok   = (32'(rd_col) >= 32'(COL_BASE)) && (rd_off < 32'(COLS));

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push  = store && col_ok && (!full || pop);

    assign head = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign {head_idx, head_side, head_vdist, head_tex} = head;

    // Short distances saturate at MAX_HEIGHT; this also covers vdist == 0.
    assign head_prod = 32'(head_vdist) * 32'(MAX_HEIGHT);
    assign clamp     = (head_prod <= 32'(HEIGHT_NUM));

    // One restoring step: compare against divisor shifted to the current bit.
    assign div_sh   = 32'(w_vdist) << bit_cnt;
    assign take     = (rem >= div_sh);
    assign rem_next = take ? (rem - div_sh) : rem;
    assign q_next   = take ? (q | (8'd1 << bit_cnt)) : q;

    // FIFO pointers; reset drops everything queued
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // FIFO storage, indexed by the write pointer
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {col_off[IDX_W-1:0], side, vdist, tex};
    end

    // Sticky flag for a store lost to a full FIFO
    always_ff @(posedge clk) begin
        if (reset) overflow <= 1'b0;
        else if (store && col_ok && full && !pop) overflow <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = clamp ? WRITE : DIV;
            DIV:     if (bit_cnt == 3'd0) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: FIFO pop, RAM write enable, busy
    always_comb begin
        pop  = (state == IDLE) && !empty;
        we   = (state == WRITE);
        busy = !empty || (state != IDLE);
    end

    // Load the head entry on pop, then run the divider one bit per cycle
    always_ff @(posedge clk) begin
        if (pop) begin
            w_idx   <= head_idx;
            w_side  <= head_side;
            w_vdist <= head_vdist;
            w_tex   <= head_tex;
            rem     <= 32'(HEIGHT_NUM);
            bit_cnt <= 3'd7;
            q       <= '0;
            height  <= 8'(MAX_HEIGHT);
        end else if (state == DIV) begin
            rem     <= rem_next;
            q       <= q_next;
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) height <= q_next;
        end
    end

    // Column buffer write; contents survive reset
    always_ff @(posedge clk) begin
        if (we) ram[w_idx] <= {height, w_side, w_tex};
    end

    // Registered read; same-index write in the same cycle yields old data
    always_ff @(posedge clk) begin
        if (reset)      {rd_height, rd_side, rd_tex} <= '0;
        else if (rd_ok) {rd_height, rd_side, rd_tex} <= ram[rd_off[IDX_W-1:0]];
        else            {rd_height, rd_side, rd_tex} <= '0;
    end
endmodule
